// File: rtl/muldiv_unit_with_lock_pkg.sv
// Shared types, latencies and the wrap-around age compare for the lock/muldiv block and its peers.
package muldiv_unit_with_lock_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCKED,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_t;

  localparam int unsigned MUL_LATENCY = 3;
  localparam int unsigned DIV_LATENCY = 34;
  localparam int unsigned DIV_ITERS   = 32;

  // a is older than b when (a - b) is negative as a width-bit two's-complement value.
  function automatic logic id_older(input logic [31:0] a, input logic [31:0] b,
                                    input int unsigned width);
    logic [31:0] diff;
    diff = a - b;
    return diff[5'(width - 1)];
  endfunction

endpackage

// File: rtl/muldiv_unit_with_lock_if.sv
// Requester-side bundle: lock request/ID, operation start and operands in; grant, result pulse and busy out.
interface muldiv_unit_with_lock_if #(
  parameter int NUM_PORTS = 8,
  parameter int ID_WIDTH  = 16
);
  logic [NUM_PORTS-1:0]               lock_req;
  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] lock_id;
  logic [NUM_PORTS-1:0]               op_valid;
  logic [NUM_PORTS-1:0][1:0]          op;
  logic [NUM_PORTS-1:0][31:0]         op_a;
  logic [NUM_PORTS-1:0][31:0]         op_b;
  logic [NUM_PORTS-1:0]               grant;
  logic [NUM_PORTS-1:0]               ans_valid;
  logic [NUM_PORTS-1:0][31:0]         ans_hi;
  logic [NUM_PORTS-1:0][31:0]         ans_lo;
  logic                               busy;

  modport master (
    output lock_req, lock_id, op_valid, op, op_a, op_b,
    input  grant, ans_valid, ans_hi, ans_lo, busy
  );

  modport slave (
    input  lock_req, lock_id, op_valid, op, op_a, op_b,
    output grant, ans_valid, ans_hi, ans_lo, busy
  );
endinterface

// File: rtl/muldiv_unit_with_lock_divider_core.sv
// Restoring 32-bit divider on magnitudes with sign fix-up; done pulses 33 cycles after start.
// No backpressure: start always (re)launches a division, abandoning any run in progress.
module muldiv_divider_core
  import muldiv_unit_with_lock_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  logic        run_q, neg_quo_q, neg_rem_q, dbz_q;
  logic [5:0]  cnt_q;
  logic [31:0] div_q, quo_q, rem_q, a_q;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh, trial;

  assign a_mag  = (is_signed && a[31]) ? -a : a;
  assign b_mag  = (is_signed && b[31]) ? -b : b;
  assign rem_sh = {rem_q, quo_q[31]};
  assign trial  = rem_sh - {1'b0, div_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      cnt_q     <= '0;
      div_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      a_q       <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run_q     <= 1'b1;
        cnt_q     <= '0;
        quo_q     <= a_mag;
        rem_q     <= '0;
        div_q     <= b_mag;
        a_q       <= a;
        dbz_q     <= (b == 32'd0);
        neg_quo_q <= is_signed && (a[31] ^ b[31]);
        neg_rem_q <= is_signed && a[31];
      end else if (run_q) begin
        if (cnt_q != 6'(DIV_ITERS)) begin
          cnt_q <= cnt_q + 6'd1;
          if (!trial[32]) begin
            rem_q <= trial[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
          end else begin
            rem_q <= rem_sh[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
          end
        end else begin
          run_q <= 1'b0;
          done  <= 1'b1;
          // Divide by zero returns all-ones quotient and the untouched dividend.
          if (dbz_q) begin
            quotient  <= 32'hFFFF_FFFF;
            remainder <= a_q;
          end else begin
            quotient  <= neg_quo_q ? -quo_q : quo_q;
            remainder <= neg_rem_q ? -rem_q : rem_q;
          end
        end
      end
    end
  end

endmodule

// File: rtl/muldiv_unit_with_lock.sv
// Lock-arbitrated MULT/MULTU/DIV/DIVU unit: oldest requester wins, result 3 (mul) or 34 (div) cycles after accept.
// No backpressure on results; op_valid is only accepted from the owner while LOCKED, release aborts any operation.
module muldiv_unit_with_lock
  import muldiv_unit_with_lock_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int ID_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  muldiv_unit_with_lock_if.slave  bus
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  muldiv_state_t    state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d, winner;
  logic             any_req, owner_req, owner_op_valid, accept, owner_is_div;
  muldiv_op_t       owner_op, op_q;
  logic [31:0]      a_q, b_q, ans_hi_q, ans_lo_q;
  logic [1:0]       cnt_q;
  logic [63:0]      a_ext, b_ext, product;
  logic             div_done;
  logic [31:0]      div_quo, div_rem;

  // Scan keeps the earlier port on equal IDs since only a strictly older ID displaces it.
  always_comb begin : arbitrate
    winner  = '0;
    any_req = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.lock_req[i] &&
          (!any_req || id_older(32'(bus.lock_id[i]), 32'(bus.lock_id[winner]), ID_WIDTH))) begin
        winner = IDX_W'(i);
      end
      any_req = any_req | bus.lock_req[i];
    end
  end

  assign owner_req      = bus.lock_req[owner_q];
  assign owner_op_valid = bus.op_valid[owner_q];
  assign owner_op       = muldiv_op_t'(bus.op[owner_q]);
  assign owner_is_div   = (owner_op == OP_DIV) || (owner_op == OP_DIVU);
  assign accept         = (state_q == ST_LOCKED) && owner_req && owner_op_valid;

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_LOCKED;
          owner_d = winner;
        end
      end
      ST_LOCKED: begin
        if (!owner_req)          state_d = ST_IDLE;
        else if (owner_op_valid) state_d = owner_is_div ? ST_DIV : ST_MUL;
      end
      ST_MUL: begin
        if (!owner_req)                           state_d = ST_IDLE;
        else if (cnt_q == 2'(MUL_LATENCY - 1))    state_d = ST_DONE;
      end
      ST_DIV: begin
        if (!owner_req)    state_d = ST_IDLE;
        else if (div_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = owner_req ? ST_LOCKED : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands are extended by signedness so one 64-bit multiply serves MULT and MULTU.
  assign a_ext   = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign b_ext   = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign product = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst_n) begin : datapath
    if (!rst_n) begin
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      ans_hi_q <= '0;
      ans_lo_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= owner_op;
        a_q   <= bus.op_a[owner_q];
        b_q   <= bus.op_b[owner_q];
        cnt_q <= '0;
      end else if (state_q == ST_MUL) begin
        cnt_q <= cnt_q + 2'd1;
      end
      if (state_q == ST_MUL && state_d == ST_DONE) begin
        ans_hi_q <= product[63:32];
        ans_lo_q <= product[31:0];
      end
      if (state_q == ST_DIV && state_d == ST_DONE) begin
        ans_hi_q <= div_rem;
        ans_lo_q <= div_quo;
      end
    end
  end

  muldiv_divider_core u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept && owner_is_div),
    .is_signed (owner_op == OP_DIV),
    .a         (bus.op_a[owner_q]),
    .b         (bus.op_b[owner_q]),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin : outputs
    bus.grant     = '0;
    bus.ans_valid = '0;
    bus.busy      = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_DONE);
    if (state_q != ST_IDLE) bus.grant[owner_q] = 1'b1;
    if (state_q == ST_DONE) bus.ans_valid[owner_q] = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.ans_hi[i] = ans_hi_q;
      bus.ans_lo[i] = ans_lo_q;
    end
  end

endmodule
